// File: rtl/sap_datapath_if.sv
// sap_datapath_if: control word and program port in, status and debug values out.
interface sap_datapath_if #(parameter int DATA_W = 8);
    logic [14:0]       ctrl;
    logic              prog_we;
    logic [3:0]        prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] out_val;
    logic              carry;
    logic              zero;
    logic              bus_err;
    logic [DATA_W-1:0] bus_dbg;
    logic [3:0]        pc_dbg;
    modport master (
        output ctrl, prog_we, prog_addr, prog_data,
        input  opcode, out_val, carry, zero, bus_err, bus_dbg, pc_dbg
    );
    modport slave (
        input  ctrl, prog_we, prog_addr, prog_data,
        output opcode, out_val, carry, zero, bus_err, bus_dbg, pc_dbg
    );
endinterface

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-style bus, registers, 16x8 RAM and adder/subtractor driven by a 15-bit control word.
module sap_datapath #(
    parameter int RAM_DEPTH = 16,
    parameter int DATA_W    = 8
) (
    input logic           clk,
    input logic           rst_n,
    sap_datapath_if.slave bus_if
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic pc_inc, pc_en, pc_load, mar_load, mdr_load, ram_en, ram_wr;
    logic ir_load, ir_en, a_load, a_en, sub, alu_en, b_load, out_load;
    logic [AW-1:0]     pc, mar;
    logic [DATA_W-1:0] mdr, ir, a, b, out_q, bus;
    logic [DATA_W-1:0] d_pc, d_ram, d_ir, d_a, d_alu;
    logic [DATA_W:0]   sum;
    logic [2:0]        n_drv;
    logic              carry_q, zero_q, err_q;
    logic [DATA_W-1:0] ram [RAM_DEPTH];

    assign pc_inc   =  bus_if.ctrl[14];
    assign pc_en    =  bus_if.ctrl[13];
    assign pc_load  =  bus_if.ctrl[12];
    assign mar_load = ~bus_if.ctrl[11];
    assign mdr_load = ~bus_if.ctrl[10];
    assign ram_en   = ~bus_if.ctrl[9];
    assign ram_wr   = ~bus_if.ctrl[8];
    assign ir_load  = ~bus_if.ctrl[7];
    assign ir_en    = ~bus_if.ctrl[6];
    assign a_load   = ~bus_if.ctrl[5];
    assign a_en     =  bus_if.ctrl[4];
    assign sub      =  bus_if.ctrl[3];
    assign alu_en   =  bus_if.ctrl[2];
    assign b_load   = ~bus_if.ctrl[1];
    assign out_load = ~bus_if.ctrl[0];

    // Subtraction is a + ~b + 1, so carry means "no borrow".
    assign sum = {1'b0, a} + {1'b0, sub ? ~b : b} + (DATA_W+1)'(sub);

    // Contending drivers wire-OR onto the bus and are flagged rather than resolved.
    assign d_pc  = pc_en  ? DATA_W'(pc)          : '0;
    assign d_ram = ram_en ? ram[mar]             : '0;
    assign d_ir  = ir_en  ? DATA_W'(ir[3:0])     : '0;
    assign d_a   = a_en   ? a                    : '0;
    assign d_alu = alu_en ? sum[DATA_W-1:0]      : '0;
    assign bus   = d_pc | d_ram | d_ir | d_a | d_alu;
    assign n_drv = 3'(pc_en) + 3'(ram_en) + 3'(ir_en) + 3'(a_en) + 3'(alu_en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= '0;
            mar     <= '0;
            mdr     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pc_load) pc <= bus[AW-1:0];
            else if (pc_inc) pc <= pc + AW'(1);
            if (mar_load) mar <= bus[AW-1:0];
            if (mdr_load) mdr <= bus;
            if (ir_load) ir <= bus;
            if (a_load) a <= bus;
            if (b_load) b <= bus;
            if (out_load) out_q <= bus;
            if (alu_en) begin
                carry_q <= sum[DATA_W];
                zero_q  <= (sum[DATA_W-1:0] == '0);
            end
            if (n_drv > 3'd1) err_q <= 1'b1;
        end
    end

    // RAM survives reset; the program port has priority over a sequencer store.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (bus_if.prog_we) ram[bus_if.prog_addr] <= bus_if.prog_data;
            else if (ram_wr) ram[mar] <= mdr;
        end
    end

    assign bus_if.opcode  = ir[DATA_W-1 -: 4];
    assign bus_if.out_val = out_q;
    assign bus_if.carry   = carry_q;
    assign bus_if.zero    = zero_q;
    assign bus_if.bus_err = err_q;
    assign bus_if.bus_dbg = bus;
    assign bus_if.pc_dbg  = pc;
endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed test-plan sequences plus random control words against a behavioural model.
module tb_sap_datapath;
    localparam logic [14:0] IDLE   = 15'h0FE3;
    localparam logic [14:0] PC_INC = 15'h4000, PC_EN = 15'h2000, PC_LD = 15'h1000;
    localparam logic [14:0] MAR_LD = 15'h0800, MDR_LD = 15'h0400, RAM_EN = 15'h0200, RAM_WR = 15'h0100;
    localparam logic [14:0] IR_LD  = 15'h0080, IR_EN = 15'h0040, A_LD = 15'h0020, A_EN = 15'h0010;
    localparam logic [14:0] SUB    = 15'h0008, ALU_EN = 15'h0004, B_LD = 15'h0002, OUT_LD = 15'h0001;
    localparam logic [14:0] DRV    = PC_EN | RAM_EN | IR_EN | A_EN | ALU_EN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    sap_datapath_if #(.DATA_W(8)) dif ();
    sap_datapath dut (.clk(clk), .rst_n(rst_n), .bus_if(dif));

    always #5 clk = ~clk;

    int         m_pc, m_mar;
    logic [7:0] m_mdr, m_ir, m_a, m_b, m_out;
    logic       m_c, m_z, m_err, m_valid;
    logic [7:0] m_ram [16];

    function automatic logic [14:0] cw(input logic [14:0] on);
        return IDLE ^ on;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mbus(input logic [14:0] c, output logic multi);
        int n = 0;
        int s = m_a + (c[3] ? 256 - m_b : m_b);
        logic [7:0] v = 8'h00;
        if (c[13])  begin v |= 8'(m_pc);       n++; end
        if (!c[9])  begin v |= m_ram[m_mar];   n++; end
        if (!c[6])  begin v |= {4'h0, m_ir[3:0]}; n++; end
        if (c[4])   begin v |= m_a;            n++; end
        if (c[2])   begin v |= 8'(s % 256);    n++; end
        multi = (n > 1);
        return v;
    endfunction

    task automatic step(input logic [14:0] c, input logic we = 1'b0, input logic [3:0] ad = 4'h0,
                        input logic [7:0] d = 8'h00, input logic rn = 1'b1);
        logic       multi;
        logic [7:0] mb;
        int         s;
        dif.ctrl = c;
        dif.prog_we = we;
        dif.prog_addr = ad;
        dif.prog_data = d;
        rst_n = rn;
        @(negedge clk);
        mb = mbus(c, multi);
        s = m_a + (c[3] ? 256 - m_b : m_b);
        if (m_valid) check("bus", dif.bus_dbg, mb);
        if (!rn) begin
            m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
            m_c = 0; m_z = 0; m_err = 0; m_valid = 1;
        end else begin
            if (we) m_ram[ad] = d;
            else if (!c[8]) m_ram[m_mar] = m_mdr;
            if (c[12]) m_pc = mb[3:0];
            else if (c[14]) m_pc = (m_pc + 1) % 16;
            if (!c[11]) m_mar = mb[3:0];
            if (!c[10]) m_mdr = mb;
            if (!c[7])  m_ir = mb;
            if (!c[5])  m_a = mb;
            if (!c[1])  m_b = mb;
            if (!c[0])  m_out = mb;
            if (c[2]) begin m_c = (s > 255); m_z = (s % 256 == 0); end
            if (multi) m_err = 1;
        end
        @(posedge clk);
        #1;
        if (m_valid) begin
            check("pc", 16'(dif.pc_dbg), 16'(m_pc));
            check("opcode", 16'(dif.opcode), 16'(m_ir[7:4]));
            check("out_val", 16'(dif.out_val), 16'(m_out));
            check("carry", 16'(dif.carry), 16'(m_c));
            check("zero", 16'(dif.zero), 16'(m_z));
            check("bus_err", 16'(dif.bus_err), 16'(m_err));
        end
    endtask

    // Route a constant onto the bus through RAM at the current MAR.
    task automatic put(input logic [14:0] load, input logic [7:0] v);
        step(IDLE, 1'b1, 4'(m_mar), v);
        step(cw(RAM_EN | load));
    endtask

    initial begin
        logic [14:0] c;
        m_valid = 0;
        dif.ctrl = IDLE; dif.prog_we = 0; dif.prog_addr = 0; dif.prog_data = 0;
        step(15'h4000, 0, 0, 0, 0);
        check("rst_pc", 16'(dif.pc_dbg), 16'h0);
        check("rst_out", 16'(dif.out_val), 16'h0);
        check("rst_opcode", 16'(dif.opcode), 16'h0);
        check("rst_err", 16'(dif.bus_err), 16'h0);
        step(IDLE, 0, 0, 0, 0);
        check("rst_bus", 16'(dif.bus_dbg), 16'h0);
        for (int i = 0; i < 16; i++) step(IDLE, 1'b1, 4'(i), 8'($urandom));

        step(IDLE, 1'b1, 4'h0, 8'h4E);
        step(15'h27E3);
        step(15'h4D63);
        check("fetch_opcode", 16'(dif.opcode), 16'h4);
        check("fetch_pc", 16'(dif.pc_dbg), 16'h1);
        step(cw(IR_EN));
        check("fetch_operand", 16'(dif.bus_dbg), 16'h0E);

        put(A_LD, 8'h07);
        put(B_LD, 8'hFB);
        step(cw(ALU_EN | A_LD));
        check("add_carry", 16'(dif.carry), 16'h1);
        check("add_zero", 16'(dif.zero), 16'h0);
        step(cw(A_EN));
        check("add_a", 16'(dif.bus_dbg), 16'h02);
        put(A_LD, 8'h05);
        put(B_LD, 8'h05);
        step(cw(SUB | ALU_EN | A_LD));
        check("sub_carry", 16'(dif.carry), 16'h1);
        check("sub_zero", 16'(dif.zero), 16'h1);
        step(cw(A_EN));
        check("sub_a", 16'(dif.bus_dbg), 16'h00);

        put(A_LD, 8'h5A);
        put(MAR_LD, 8'h03);
        step(IDLE, 1'b1, 4'h3, 8'h00);
        step(cw(A_EN | MDR_LD));
        step(cw(RAM_WR));
        step(cw(RAM_EN));
        check("store", 16'(dif.bus_dbg), 16'h5A);
        put(A_LD, 8'hC3);
        step(IDLE, 1'b1, 4'h3, 8'h00);
        step(cw(A_EN | MDR_LD | RAM_WR));
        step(cw(RAM_EN));
        check("store_old_mdr", 16'(dif.bus_dbg), 16'h5A);
        step(cw(RAM_WR));
        step(cw(RAM_EN));
        check("store_new_mdr", 16'(dif.bus_dbg), 16'hC3);
        step(cw(RAM_WR), 1'b1, 4'h3, 8'h11);
        step(cw(RAM_EN));
        check("prog_wins", 16'(dif.bus_dbg), 16'h11);
        step(cw(RAM_EN | RAM_WR));

        put(PC_LD, 8'h03);
        put(A_LD, 8'h50);
        step(cw(PC_EN | A_EN));
        check("conflict_bus", 16'(dif.bus_dbg), 16'h53);
        check("conflict_err", 16'(dif.bus_err), 16'h1);
        for (int i = 0; i < 5; i++) step(IDLE);
        check("err_sticky", 16'(dif.bus_err), 16'h1);
        step(IDLE, 0, 0, 0, 0);
        check("err_cleared", 16'(dif.bus_err), 16'h0);

        put(PC_LD, 8'h0F);
        step(cw(PC_INC));
        check("pc_wrap", 16'(dif.pc_dbg), 16'h0);
        put(IR_LD, 8'h79);
        step(cw(PC_INC | PC_LD | IR_EN));
        check("pc_load_wins", 16'(dif.pc_dbg), 16'h9);

        for (int i = 0; i < 600; i++) begin
            c = 15'($urandom);
            case ($urandom_range(0, 7))
                0: c = (c & ~DRV) | (IDLE & DRV) ^ PC_EN;
                1: c = (c & ~DRV) | (IDLE & DRV) ^ RAM_EN;
                2: c = (c & ~DRV) | (IDLE & DRV) ^ IR_EN;
                3: c = (c & ~DRV) | (IDLE & DRV) ^ A_EN;
                4: c = (c & ~DRV) | (IDLE & DRV) ^ ALU_EN;
                5: c = (c & ~DRV) | (IDLE & DRV);
                default: ;
            endcase
            step(c, $urandom_range(0, 3) == 0, 4'($urandom), 8'($urandom), $urandom_range(0, 39) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
